// File: rtl/nf_dump_pkg.sv
// nf_dump_pkg: shared FSM states, ASCII constants and hex encoder for the register dump
package nf_dump_pkg;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CAPT, S_CHAR, S_WAIT, S_NEXT, S_FIN} state_t;

    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] HEX0  = 8'h30;
    localparam logic [7:0] HEXA  = 8'h41;
    localparam int         LINE_LEN = 13;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? HEX0 + {4'd0, n} : HEXA + {4'd0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/nf_uart_tx.sv
// nf_uart_tx: 8N1 UART transmitter, one byte per tx_req, tx_busy covers the whole frame
module nf_uart_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy
);

    localparam int            BW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BMAX = BW'(BAUD_DIV - 1);

    logic [BW-1:0] baud_q;
    logic [3:0]    bit_q;
    logic [8:0]    shift_q;
    logic          busy_q;
    logic          tx_q;
    logic          wrap;

    assign wrap    = busy_q && (baud_q == BMAX);
    assign tx      = tx_q;
    assign tx_busy = busy_q | tx_req;

    // tx is registered so the line is glitch-free; the stop bit rides in as the shifted-in ones
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else if (!busy_q) begin
            if (tx_req) begin
                busy_q  <= 1'b1;
                tx_q    <= 1'b0;
                shift_q <= {1'b1, tx_data};
                baud_q  <= '0;
                bit_q   <= '0;
            end
        end else begin
            baud_q <= wrap ? '0 : baud_q + 1'b1;
            if (wrap) begin
                bit_q   <= bit_q + 4'd1;
                tx_q    <= shift_q[0];
                shift_q <= {1'b1, shift_q[8:1]};
                if (bit_q == 4'd9)
                    busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/nf_reg_dump_uart.sv
// nf_reg_dump_uart: walks the CPU register-scan port and prints each register as an ASCII line over UART
module nf_reg_dump_uart
    import nf_dump_pkg::*;
#(
    parameter int REG_NUM  = 32,
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST      = 5'(REG_NUM - 1);
    localparam logic [3:0] LAST_CHAR = 4'(LINE_LEN - 1);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  char_q, char_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] nib_sh;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        tx_busy;

    assign reg_addr = idx_q;
    assign busy     = state_q != S_IDLE;
    assign done     = state_q == S_FIN;
    assign nib_sh   = shadow_q << {char_q - 4'd3, 2'b00};
    assign tx_data  = (char_q == 4'd0)  ? hex_ascii({3'b000, idx_q[4]}) :
                      (char_q == 4'd1)  ? hex_ascii(idx_q[3:0]) :
                      (char_q == 4'd2)  ? COLON :
                      (char_q == 4'd11) ? CR :
                      (char_q == 4'd12) ? LF : hex_ascii(nib_sh[31:28]);

    // state, register index, character index and the tear-proof shadow copy
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            char_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            char_q   <= char_d;
            shadow_q <= shadow_d;
        end
    end

    // dump sequencing: one line per register, one UART byte per character
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        char_d   = char_q;
        shadow_d = shadow_q;
        tx_req   = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_ADDR;
            S_ADDR: state_d = S_CAPT;
            S_CAPT: begin
                shadow_d = reg_data;
                char_d   = '0;
                state_d  = S_CHAR;
            end
            S_CHAR: begin
                tx_req  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: if (!tx_busy) begin
                if (char_q == LAST_CHAR) state_d = S_NEXT;
                else begin
                    char_d  = char_q + 4'd1;
                    state_d = S_CHAR;
                end
            end
            S_NEXT: if (idx_q == LAST) state_d = S_FIN;
            else begin
                idx_d   = idx_q + 5'd1;
                state_d = S_ADDR;
            end
            S_FIN: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    nf_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk     (clk),
        .resetn  (resetn),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

endmodule

// File: tb/tb_nf_reg_dump_uart.sv
// tb_nf_reg_dump_uart: three dumpers (1, 2 and 32 registers) decoded by a UART receiver and compared with string-built lines
module tb_nf_reg_dump_uart;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [2:0]  start = '0;
    logic [4:0]  a0, a1, a2;
    logic        tx0, tx1, tx2, b0, b1, b2, d0, d1, d2;
    logic [2:0]  txv, bsy, dn;
    logic [31:0] m1;
    logic [31:0] m2 [2];
    logic [31:0] m32 [32];
    logic [31:0] rd0, rd1, rd2;

    always #5 clk = ~clk;

    assign rd0 = m1;
    assign rd1 = m2[a1[0]];
    assign rd2 = m32[a2];
    assign txv = {tx2, tx1, tx0};
    assign bsy = {b2, b1, b0};
    assign dn  = {d2, d1, d0};

    nf_reg_dump_uart #(.REG_NUM(1), .BAUD_DIV(4)) u1 (.clk(clk), .resetn(resetn), .start(start[0]),
        .reg_addr(a0), .reg_data(rd0), .tx(tx0), .busy(b0), .done(d0));
    nf_reg_dump_uart #(.REG_NUM(2), .BAUD_DIV(4)) u2 (.clk(clk), .resetn(resetn), .start(start[1]),
        .reg_addr(a1), .reg_data(rd1), .tx(tx1), .busy(b1), .done(d1));
    nf_reg_dump_uart #(.REG_NUM(32), .BAUD_DIV(4)) u32 (.clk(clk), .resetn(resetn), .start(start[2]),
        .reg_addr(a2), .reg_data(rd2), .tx(tx2), .busy(b2), .done(d2));

    // receiver state per channel; every sample of a bit must match its first sample (4-clock bits)
    int          ph [3];
    bit          inf [3];
    logic        bv [3];
    logic [7:0]  cur [3];
    byte unsigned rxb [3][1024];
    int          rxn [3];
    int          ndone [3];
    int          nbad;
    int          visits [128];
    int          nvis;
    int          lasta = -1;
    int          ntot, npass, now;

    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (dn[c]) ndone[c]++;
            if (resetn) inf[c] = 1'b0;
            else if (!inf[c]) begin
                if (txv[c] == 1'b0) begin
                    inf[c] = 1'b1;
                    ph[c]  = 0;
                    bv[c]  = 1'b0;
                end
            end else begin
                ph[c]++;
                if (ph[c] % 4 == 0) begin
                    bv[c] = txv[c];
                    if (ph[c] >= 4 && ph[c] <= 32) cur[c][ph[c]/4-1] = txv[c];
                end else if (txv[c] !== bv[c]) nbad++;
                if (ph[c] == 39) begin
                    if (bv[c] !== 1'b1) nbad++;
                    if (rxn[c] < 1024) rxb[c][rxn[c]] = cur[c];
                    rxn[c]++;
                    inf[c] = 1'b0;
                end
            end
        end
        if (b2 && int'(a2) != lasta) begin
            if (nvis < 128) visits[nvis] = int'(a2);
            nvis++;
            lasta = int'(a2);
        end
    end

    function automatic string exp_line(int i, logic [31:0] d);
        string hx = "0123456789ABCDEF";
        string r;
        int    n;
        r = {hx.substr(i / 16, i / 16), hx.substr(i % 16, i % 16), ":"};
        for (int k = 7; k >= 0; k--) begin
            n = int'((d >> (4 * k)) & 32'hF);
            r = {r, hx.substr(n, n)};
        end
        return {r, "\r\n"};
    endfunction

    function automatic string got_str(int c, int base, int n);
        string r = "";
        for (int j = 0; j < n; j++) r = {r, $sformatf("%c", rxb[c][(base + j) % 1024])};
        return r;
    endfunction

    function automatic string esc(string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, (s[i] < 8'h20) ? string'("~") : $sformatf("%c", s[i])};
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chks(string nm, string act, string exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got \"%s\" expected \"%s\"", nm, esc(act), esc(exp));
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        now++;
    endtask

    task automatic pulse(int c);
        start[c] = 1'b1;
        tick();
        start[c] = 1'b0;
    endtask

    task automatic wait_done(int c, int budget, string nm);
        int s = ndone[c];
        int n = 0;
        while (ndone[c] == s && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_done_seen"}, 64'(ndone[c] > s), 64'd1);
    endtask

    task automatic wait_bytes(int c, int target, int budget, string nm);
        int n = 0;
        while (rxn[c] < target && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_bytes_reached"}, 64'(rxn[c] >= target), 64'd1);
    endtask

    typedef struct {
        logic [31:0] d;
        string       exp;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int b, dc, v0, errs, lat, ts, n;
        tbl[0] = '{32'hDEADBEEF, "00:DEADBEEF\r\n"};
        tbl[1] = '{32'h00000000, "00:00000000\r\n"};
        tbl[2] = '{32'hFFFFFFFF, "00:FFFFFFFF\r\n"};
        tbl[3] = '{32'h0123ABCD, "00:0123ABCD\r\n"};
        tbl[4] = '{32'h9A5F0C6E, "00:9A5F0C6E\r\n"};
        m1 = '0;
        m2[0] = '0;
        m2[1] = '0;
        for (int i = 0; i < 32; i++) m32[i] = '0;
        repeat (3) tick();
        chk("reset_tx", 64'(txv), 64'h7);
        chk("reset_busy", 64'(bsy), 64'h0);
        chk("reset_done", 64'(dn), 64'h0);
        chk("reset_addr", 64'({a0, a1, a2}), 64'h0);
        resetn = 1'b0;

        errs = 0;
        repeat (200) begin
            tick();
            if (txv !== 3'b111 || bsy !== 3'b000 || dn !== 3'b000 || {a0, a1, a2} !== 15'd0) errs++;
        end
        chk("idle_200_cycles", 64'(errs), 64'd0);

        for (int i = 0; i < 5; i++) begin
            m1 = tbl[i].d;
            b  = rxn[0];
            dc = ndone[0];
            pulse(0);
            ts = now;
            if (i == 0) begin
                lat = 0;
                while (txv[0] === 1'b1 && lat < 20) begin
                    tick();
                    lat++;
                end
                chk("start_latency_le4", 64'(lat <= 4), 64'd1);
            end
            wait_done(0, 700, "tbl");
            if (i == 0) chk("done_within_567", 64'(now - ts <= 567), 64'd1);
            repeat (5) tick();
            chks("tbl_line", got_str(0, b, 13), tbl[i].exp);
            chk("tbl_bytes", 64'(rxn[0] - b), 64'd13);
            chk("tbl_done_once", 64'(ndone[0] - dc), 64'd1);
            chk("tbl_idle_after", 64'(b0), 64'd0);
        end

        for (int i = 0; i < 3; i++) begin
            m1 = $urandom;
            b  = rxn[0];
            pulse(0);
            wait_done(0, 700, "rnd1");
            repeat (3) tick();
            chks("rnd1_line", got_str(0, b, 13), exp_line(0, m1));
        end

        m1 = $urandom;
        b  = rxn[0];
        pulse(0);
        n = 0;
        while (d0 !== 1'b1 && n < 700) begin
            tick();
            n++;
        end
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (20) tick();
        chk("fin_start_ignored_busy", 64'(b0), 64'd0);
        chk("fin_start_ignored_bytes", 64'(rxn[0] - b), 64'd13);
        pulse(0);
        n = 0;
        while (d0 !== 1'b1 && n < 700) begin
            tick();
            n++;
        end
        tick();
        b = rxn[0];
        pulse(0);
        tick();
        chk("start_after_fin_busy", 64'(b0), 64'd1);
        wait_done(0, 700, "after_fin");
        repeat (3) tick();
        chks("after_fin_line", got_str(0, b, 13), exp_line(0, m1));

        m2[0] = $urandom;
        m2[1] = $urandom;
        b  = rxn[1];
        dc = ndone[1];
        pulse(1);
        repeat (49) tick();
        pulse(1);
        repeat (249) tick();
        pulse(1);
        wait_done(1, 1500, "two");
        repeat (60) tick();
        chk("two_bytes", 64'(rxn[1] - b), 64'd26);
        chk("two_done_once", 64'(ndone[1] - dc), 64'd1);
        chks("two_line0", got_str(1, b, 13), exp_line(0, m2[0]));
        chks("two_line1", got_str(1, b + 13, 13), exp_line(1, m2[1]));

        for (int i = 0; i < 32; i++) m32[i] = i * 32'h01010101;
        b  = rxn[2];
        dc = ndone[2];
        v0 = nvis;
        pulse(2);
        wait_done(2, 20000, "full");
        repeat (5) tick();
        chk("full_bytes", 64'(rxn[2] - b), 64'd416);
        chk("full_done_once", 64'(ndone[2] - dc), 64'd1);
        chks("full_line31", got_str(2, b + 31 * 13, 13), "1F:1F1F1F1F\r\n");
        errs = 0;
        for (int i = 0; i < 32; i++) if (got_str(2, b + 13 * i, 13) != exp_line(i, m32[i])) errs++;
        chk("full_all_lines", 64'(errs), 64'd0);
        chk("full_addr_visits", 64'(nvis - v0), 64'd32);
        errs = 0;
        for (int k = 0; k < 32; k++) if (visits[(v0 + k) % 128] != k) errs++;
        chk("full_addr_order", 64'(errs), 64'd0);

        m32[3] = 32'h11111111;
        b = rxn[2];
        pulse(2);
        wait_bytes(2, b + 3 * 13 + 4, 6000, "tear");
        m32[3] = 32'h22222222;
        wait_done(2, 20000, "tear");
        repeat (3) tick();
        chks("tear_line3", got_str(2, b + 39, 13), "03:11111111\r\n");
        chks("tear_line4", got_str(2, b + 52, 13), exp_line(4, m32[4]));

        m1 = $urandom & 32'hFF0FFFFF;
        b  = rxn[0];
        pulse(0);
        wait_bytes(0, b + 5, 800, "midrst");
        n = 0;
        while (txv[0] === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        repeat (10) tick();
        chk("midrst_tx_low_before", 64'(tx0), 64'd0);
        #2 resetn = 1'b1;
        #1;
        chk("midrst_tx_async_high", 64'(tx0), 64'd1);
        chk("midrst_busy_async_low", 64'(b0), 64'd0);
        chk("midrst_addr_zero", 64'(a0), 64'd0);
        tick();
        tick();
        resetn = 1'b0;
        tick();
        m1 = $urandom;
        b  = rxn[0];
        pulse(0);
        wait_done(0, 700, "post_rst");
        repeat (3) tick();
        chks("post_rst_line", got_str(0, b, 13), exp_line(0, m1));

        chk("frame_errors", 64'(nbad), 64'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/nf_reg_dump_uart.md
Name: nf_reg_dump_uart

Overview:
- Debug consumer of the CPU's register-scan port; sits directly downstream of the processor top.
- On a start pulse it walks reg_addr from 0 to REG_NUM-1 and captures reg_data for each register.
- It serialises each register as an ASCII line over an 8N1 UART transmit pin.
- Lets the team dump the register file to a host terminal without a debugger.

Parameters:
- REG_NUM, 32: number of registers dumped. Legal range 1..32. Index width is fixed at 5 bits.
- BAUD_DIV, 434: clocks per UART bit (50 MHz / 115200). Minimum 2.

Ports:
- clk  input  1  clock
- resetn  input  1  reset: asynchronous, active-high (1 = reset asserted) despite the port name
- start  input  1  single-cycle request to begin a dump
- reg_addr  output  5  scan register address driven to the CPU
- reg_data  input  32  scan register data from the CPU (combinational from reg_addr)
- tx  output  1  UART serial out, idle high
- busy  output  1  high while a dump is in progress
- done  output  1  one-cycle pulse after the final stop bit of the last line

Behaviour:
- Reset values: tx=1, busy=0, done=0, reg_addr=0. FSM goes to IDLE, all counters cleared.
- Reset mid-operation aborts immediately. tx returns high asynchronously, even if that truncates a frame.
- Line format per register i: two uppercase hex digits of i, ':', eight uppercase hex digits of reg_data (MSB nibble first), CR (0x0D), LF (0x0A). That is 13 characters.
- Hex encoding: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46.
- FSM states: IDLE, ADDR, CAPT, CHAR, WAIT, NEXT, FIN.
- IDLE: on start=1, go to ADDR and set busy=1. While busy=1, start is ignored.
- ADDR: drive reg_addr=i for one cycle so the CPU's combinational read settles.
- CAPT: latch reg_data into a 32-bit shadow register. Later CPU activity must not tear the line. Clear the char index to 0.
- CHAR: select character[char_idx] from {index, shadow}, assert tx_req for one cycle, go to WAIT.
- WAIT: hold until the sub-module's tx_busy falls. If char_idx<12, increment it and go to CHAR; otherwise go to NEXT.
- NEXT: if i==REG_NUM-1, go to FIN; otherwise increment i and go to ADDR.
- FIN: pulse done=1 for one cycle, set busy=0, clear reg_addr to 0, go to IDLE.
- A start arriving in the same cycle as the FIN state is ignored. A start one cycle later begins a new dump.
- Latency: the falling edge of the first start bit occurs ≤4 clocks after start is sampled.
- Inter-character gap: ≤3 clocks of idle-high between a stop bit end and the next start bit.
- UART frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly BAUD_DIV clocks.
- Baud counter: counts 0..BAUD_DIV-1 and wraps. The bit counter runs 0..9.
- tx_busy is high from the tx_req cycle until the last stop-bit clock completes.
- A tx_req arriving while tx_busy=1 is ignored by the sub-module. The FSM never issues one.

Decomposition:
- Package nf_dump_pkg holds:
  - the FSM state enum;
  - ASCII constants (COLON 0x3A, CR 0x0D, LF 0x0A, HEX0 0x30, HEXA 0x41);
  - LINE_LEN=13;
  - the hex-to-ASCII function.
- Sub-module nf_uart_tx:
  - Ports: clk, resetn, tx_req, tx_data[7:0], tx, tx_busy. Parameter BAUD_DIV.
  - Owns the baud counter, bit counter and shift register.
- The top-level block owns the dump FSM, register index, char index and shadow register.

Test Plan:
- Reset then idle, BAUD_DIV=4: with no start, tx=1, busy=0 and reg_addr=0 for 200 clocks.
- Single line, REG_NUM=1, model reg_data=0xDEADBEEF:
  - Decoded stream is "00:DEADBEEF\r\n".
  - done pulses once, ≤13*40+13*3+8 clocks after start.
  - Each bit measures exactly 4 clocks.
- Full dump, REG_NUM=32, register model x[i]=i*0x01010101:
  - 416 bytes received.
  - Line 31 is "1F:1F1F1F1F\r\n".
  - reg_addr visits 0..31 in order.
  - done pulses exactly once.
- Tear check:
  - Model changes x[3] from 0x11111111 to 0x22222222 during line 3's transmission.
  - Line 3 still reads "03:11111111".
- Start while busy: start pulses at clock 50 and clock 300 of a REG_NUM=2 dump. Output is exactly 26 bytes and there is one done pulse.
- Reset mid-frame: assert resetn=1 during the data bits of char 5. tx goes to 1 without waiting for a clock, busy=0, and a subsequent start produces a clean "00:..." line.
